pulse_scheduler: RTL and testbench

Downstream consumer of the pulse-memory fetch stage. Accepts decoded pulse descriptors (frequency, phase, amplitude, start time, length, envelope base address), buffers them in a small in-order queue, and plays each one against a free-running experiment timebase. During play it drives one sample per cycle to the NCO/envelope datapath, stepping the envelope address. Pulses whose start time has already passed are dropped and flagged.

---
 rtl/pulse_pkg.sv | 27 ++
 rtl/pulse_desc_fifo.sv | 55 +++++
 rtl/pulse_scheduler.sv | 162 ++++++++++++++++
 tb/tb_pulse_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared pulse package: register field widths, descriptor bundle and
// scheduler state encoding.
package pulse_pkg;

  localparam int PULSE_REG_FREQ_W   = 16;
  localparam int PULSE_REG_PHASE_W  = 16;
  localparam int PULSE_REG_AMP_W    = 12;
  localparam int PULSE_REG_TSTART_W = 16;
  localparam int PULSE_REG_TLEN_W   = 12;
  localparam int ENVELOPE_ADDR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PLAY
  } sched_state_e;

  typedef struct packed {
    logic [PULSE_REG_FREQ_W-1:0]   freq;
    logic [PULSE_REG_PHASE_W-1:0]  phase;
    logic [PULSE_REG_AMP_W-1:0]    amp;
    logic [PULSE_REG_TSTART_W-1:0] tstart;
    logic [PULSE_REG_TLEN_W-1:0]   tlen;
    logic [ENVELOPE_ADDR_W-1:0]    env;
  } pulse_desc_t;

endpackage

// File: rtl/pulse_desc_fifo.sv
// In-order descriptor queue with occupancy count and synchronous flush.
// Head entry is read combinationally from storage (no fall-through).
module pulse_desc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Plays queued pulse descriptors against a saturating experiment timebase,
// one envelope sample per cycle; late descriptors are dropped and flagged.
module pulse_scheduler
  import pulse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PULSE_REG_FREQ_W-1:0]   in_freq,
  input  logic [PULSE_REG_PHASE_W-1:0]  in_phase,
  input  logic [PULSE_REG_AMP_W-1:0]    in_amp,
  input  logic [PULSE_REG_TSTART_W-1:0] in_tstart,
  input  logic [PULSE_REG_TLEN_W-1:0]   in_tlen,
  input  logic [ENVELOPE_ADDR_W-1:0]    in_env_addr,
  output logic                          out_active,
  output logic                          out_first,
  output logic                          out_last,
  output logic [PULSE_REG_FREQ_W-1:0]   out_freq,
  output logic [PULSE_REG_PHASE_W-1:0]  out_phase,
  output logic [PULSE_REG_AMP_W-1:0]    out_amp,
  output logic [ENVELOPE_ADDR_W-1:0]    out_env_addr,
  output logic [PULSE_REG_TSTART_W-1:0] time_now,
  output logic                          running,
  output logic                          late_err,
  output logic [$clog2(DEPTH):0]        q_count
);

  localparam int TW = PULSE_REG_TSTART_W;
  localparam int LW = PULSE_REG_TLEN_W;
  localparam int EW = ENVELOPE_ADDR_W;

  pulse_desc_t  in_desc;
  pulse_desc_t  head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         eligible;
  logic         hd_zero;
  logic         hd_now;
  logic         hd_late;
  logic         pop;
  logic         issue;

  sched_state_e              state_q;
  logic [TW-1:0]             time_q;
  logic                      running_q;
  logic                      late_q;
  logic [LW-1:0]             tlen_q;
  logic [EW-1:0]             base_q;
  logic [LW-1:0]             idx_q;
  logic                      act_q;
  logic                      first_q;
  logic                      last_q;
  logic [PULSE_REG_FREQ_W-1:0]  freq_q;
  logic [PULSE_REG_PHASE_W-1:0] phase_q;
  logic [PULSE_REG_AMP_W-1:0]   amp_q;
  logic [EW-1:0]             env_q;

  assign in_desc = '{freq: in_freq, phase: in_phase, amp: in_amp,
                     tstart: in_tstart, tlen: in_tlen, env: in_env_addr};

  pulse_desc_fifo #(
    .W    ($bits(pulse_desc_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(start),
    .push_i (in_valid && !start),
    .data_i (in_desc),
    .pop_i  (pop),
    .data_o (head),
    .count_o(q_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Head may also issue while the last sample is on the outputs: no bubble.
  assign eligible = !fifo_empty &&
                    (state_q == ST_WAIT || (state_q == ST_PLAY && last_q));
  assign hd_zero  = head.tlen == '0;
  assign hd_now   = time_q == head.tstart;
  assign hd_late  = time_q > head.tstart;
  assign pop      = !start && eligible && (hd_zero || hd_now || hd_late);
  assign issue    = pop && !hd_zero && hd_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      late_q    <= 1'b0;
      tlen_q    <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      act_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      freq_q    <= '0;
      phase_q   <= '0;
      amp_q     <= '0;
      env_q     <= '0;
    end else if (start) begin
      state_q   <= ST_WAIT;
      time_q    <= '0;
      running_q <= 1'b1;
      late_q    <= 1'b0;
      idx_q     <= '0;
      act_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (running_q && time_q != '1) time_q <= time_q + TW'(1);
      if (pop && !hd_zero && hd_late) late_q <= 1'b1;
      unique case (state_q)
        ST_WAIT, ST_PLAY: begin
          if (issue) begin
            state_q <= ST_PLAY;
            tlen_q  <= head.tlen;
            base_q  <= head.env;
            idx_q   <= LW'(1);
            act_q   <= 1'b1;
            first_q <= 1'b1;
            last_q  <= head.tlen == LW'(1);
            freq_q  <= head.freq;
            phase_q <= head.phase;
            amp_q   <= head.amp;
            env_q   <= head.env;
          end else if (state_q == ST_PLAY && !last_q) begin
            idx_q   <= idx_q + LW'(1);
            act_q   <= 1'b1;
            first_q <= 1'b0;
            last_q  <= idx_q == tlen_q - LW'(1);
            env_q   <= base_q + EW'(idx_q);
          end else begin
            state_q <= ST_WAIT;
            act_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = !fifo_full;
  assign out_active   = act_q;
  assign out_first    = first_q;
  assign out_last     = last_q;
  assign out_freq     = freq_q;
  assign out_phase    = phase_q;
  assign out_amp      = amp_q;
  assign out_env_addr = env_q;
  assign time_now     = time_q;
  assign running      = running_q;
  assign late_err     = late_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: timing of play, back-to-back issue,
// late drop, queue full, zero-length/wrap, start and reset mid-play.
module tb_pulse_scheduler;
  import pulse_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [PULSE_REG_FREQ_W-1:0]   in_freq = '0;
  logic [PULSE_REG_PHASE_W-1:0]  in_phase = '0;
  logic [PULSE_REG_AMP_W-1:0]    in_amp = '0;
  logic [PULSE_REG_TSTART_W-1:0] in_tstart = '0;
  logic [PULSE_REG_TLEN_W-1:0]   in_tlen = '0;
  logic [ENVELOPE_ADDR_W-1:0]    in_env_addr = '0;
  logic out_active, out_first, out_last;
  logic [PULSE_REG_FREQ_W-1:0]   out_freq;
  logic [PULSE_REG_PHASE_W-1:0]  out_phase;
  logic [PULSE_REG_AMP_W-1:0]    out_amp;
  logic [ENVELOPE_ADDR_W-1:0]    out_env_addr;
  logic [PULSE_REG_TSTART_W-1:0] time_now;
  logic running, late_err;
  logic [CW-1:0] q_count;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_t  = 0;

  pulse_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_freq(in_freq), .in_phase(in_phase), .in_amp(in_amp),
    .in_tstart(in_tstart), .in_tlen(in_tlen), .in_env_addr(in_env_addr),
    .out_active(out_active), .out_first(out_first), .out_last(out_last),
    .out_freq(out_freq), .out_phase(out_phase), .out_amp(out_amp),
    .out_env_addr(out_env_addr), .time_now(time_now),
    .running(running), .late_err(late_err), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    tb_t++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tb_t = 0;
  endtask

  task automatic set_desc(input int ts, input int tl, input int env, input int fq);
    in_tstart   = PULSE_REG_TSTART_W'(ts);
    in_tlen     = PULSE_REG_TLEN_W'(tl);
    in_env_addr = ENVELOPE_ADDR_W'(env);
    in_freq     = PULSE_REG_FREQ_W'(fq);
    in_phase    = PULSE_REG_PHASE_W'(fq + 1);
    in_amp      = PULSE_REG_AMP_W'(fq + 2);
  endtask

  task automatic push(input int ts, input int tl, input int env, input int fq);
    set_desc(ts, tl, env, fq);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({out_active, out_first, out_last, running, late_err, in_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000001",
               {out_active, out_first, out_last, running, late_err, in_ready});
    end
    n_cmp++;
    if ({out_freq, out_phase, out_amp, out_env_addr, time_now, q_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got %h/%h/%h/%h/%h/%h expected all 0",
               out_freq, out_phase, out_amp, out_env_addr, time_now, q_count);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (time_now !== '0 || running !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_time: got time %0d run %b expected 0 0", time_now, running);
    end
  endtask

  task automatic test_single();
    logic exp_act;
    logic [ENVELOPE_ADDR_W-1:0] exp_env;
    do_start();
    n_cmp++;
    if (time_now !== '0 || running !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_state: got t=%0d run=%b rdy=%b expected 0 1 1",
               time_now, running, in_ready);
    end
    push(10, 4, 'h10, 'h100);
    while (tb_t < 20) begin
      tick();
      exp_act = tb_t >= 11 && tb_t <= 14;
      exp_env = ENVELOPE_ADDR_W'('h10 + tb_t - 11);
      n_cmp++;
      if (out_active !== exp_act) begin
        n_bad++;
        $display("FAIL single_active t=%0d: got %b expected %b", tb_t, out_active, exp_act);
      end
      if (exp_act) begin
        n_cmp++;
        if (out_env_addr !== exp_env ||
            {out_first, out_last} !== {tb_t == 11, tb_t == 14}) begin
          n_bad++;
          $display("FAIL single_sample t=%0d: got env %h f/l %b%b expected env %h f/l %b%b",
                   tb_t, out_env_addr, out_first, out_last, exp_env, tb_t == 11, tb_t == 14);
        end
      end
      if (tb_t == 11) begin
        n_cmp++;
        if (out_freq !== 16'h100 || out_phase !== 16'h101 || out_amp !== 12'h102) begin
          n_bad++;
          $display("FAIL single_fields: got %h %h %h expected 100 101 102",
                   out_freq, out_phase, out_amp);
        end
      end
    end
    n_cmp++;
    if (time_now !== 16'd20) begin
      n_bad++;
      $display("FAIL single_time: got %0d expected 20", time_now);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_act;
    logic [ENVELOPE_ADDR_W-1:0] exp_env;
    logic [PULSE_REG_FREQ_W-1:0] exp_fq;
    int nact;
    nact = 0;
    do_start();
    push(5, 3, 'h20, 'h111);
    push(8, 2, 'h40, 'h222);
    while (tb_t < 14) begin
      tick();
      exp_act = tb_t >= 6 && tb_t <= 10;
      exp_env = (tb_t <= 8) ? ENVELOPE_ADDR_W'('h20 + tb_t - 6)
                            : ENVELOPE_ADDR_W'('h40 + tb_t - 9);
      exp_fq  = (tb_t <= 8) ? 16'h111 : 16'h222;
      if (out_active) nact++;
      n_cmp++;
      if (out_active !== exp_act) begin
        n_bad++;
        $display("FAIL b2b_active t=%0d: got %b expected %b", tb_t, out_active, exp_act);
      end
      if (exp_act) begin
        n_cmp++;
        if (out_env_addr !== exp_env || out_freq !== exp_fq ||
            out_first !== (tb_t == 6 || tb_t == 9) ||
            out_last !== (tb_t == 8 || tb_t == 10)) begin
          n_bad++;
          $display("FAIL b2b_sample t=%0d: got env %h fq %h f/l %b%b expected env %h fq %h",
                   tb_t, out_env_addr, out_freq, out_first, out_last, exp_env, exp_fq);
        end
      end
    end
    n_cmp++;
    if (nact != 5) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d active cycles expected 5", nact);
    end
  endtask

  task automatic test_late();
    do_start();
    while (tb_t < 6) tick();
    push(2, 3, 'h00, 'h5);
    n_cmp++;
    if (q_count !== CW'(1)) begin
      n_bad++;
      $display("FAIL late_queued: got %0d expected 1", q_count);
    end
    tick();
    n_cmp++;
    if (late_err !== 1'b1 || q_count !== '0 || out_active !== 1'b0) begin
      n_bad++;
      $display("FAIL late_drop: got err %b cnt %0d act %b expected 1 0 0",
               late_err, q_count, out_active);
    end
    push(20, 2, 'h30, 'h6);
    while (tb_t < 25) begin
      tick();
      n_cmp++;
      if (out_active !== (tb_t == 21 || tb_t == 22)) begin
        n_bad++;
        $display("FAIL late_next t=%0d: got %b expected %b",
                 tb_t, out_active, tb_t == 21 || tb_t == 22);
      end
    end
    n_cmp++;
    if (late_err !== 1'b1) begin
      n_bad++;
      $display("FAIL late_sticky: got %b expected 1", late_err);
    end
  endtask

  task automatic test_full();
    do_start();
    for (int i = 0; i < 5; i++) begin
      set_desc(1000 + i, 1, i, i);
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== (i < 4)) begin
        n_bad++;
        $display("FAIL full_ready i=%0d: got %b expected %b", i, in_ready, i < 4);
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (q_count !== CW'(4) || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_count: got %0d rdy %b expected 4 0", q_count, in_ready);
    end
  endtask

  task automatic test_tlen0_wrap();
    logic [ENVELOPE_ADDR_W-1:0] exp_env;
    do_start();
    push(5, 0, 'h50, 'h7);
    push(6, 3, 'hFE, 'h8);
    n_cmp++;
    if (q_count !== CW'(1)) begin
      n_bad++;
      $display("FAIL zero_discard: got %0d expected 1", q_count);
    end
    while (tb_t < 12) begin
      tick();
      exp_env = ENVELOPE_ADDR_W'('hFE + tb_t - 7);
      n_cmp++;
      if (out_active !== (tb_t >= 7 && tb_t <= 9)) begin
        n_bad++;
        $display("FAIL wrap_active t=%0d: got %b", tb_t, out_active);
      end
      if (tb_t >= 7 && tb_t <= 9) begin
        n_cmp++;
        if (out_env_addr !== exp_env) begin
          n_bad++;
          $display("FAIL wrap_env t=%0d: got %h expected %h", tb_t, out_env_addr, exp_env);
        end
      end
    end
    n_cmp++;
    if (late_err !== 1'b0 || q_count !== '0) begin
      n_bad++;
      $display("FAIL zero_noerr: got err %b cnt %0d expected 0 0", late_err, q_count);
    end
  endtask

  task automatic test_start_rst();
    do_start();
    push(3, 10, 'h00, 'h9);
    push(50, 2, 'h00, 'hA);
    while (tb_t < 6) tick();
    n_cmp++;
    if (out_active !== 1'b1) begin
      n_bad++;
      $display("FAIL midplay_active: got %b expected 1", out_active);
    end
    set_desc(3, 4, 'h00, 'hB);
    in_valid = 1'b1;
    do_start();
    in_valid = 1'b0;
    n_cmp++;
    if (out_active !== 1'b0 || time_now !== '0 || running !== 1'b1 || q_count !== '0) begin
      n_bad++;
      $display("FAIL start_abort: got act %b t %0d run %b cnt %0d expected 0 0 1 0",
               out_active, time_now, running, q_count);
    end
    while (tb_t < 15) begin
      tick();
      n_cmp++;
      if (out_active !== 1'b0) begin
        n_bad++;
        $display("FAIL start_flushed t=%0d: got %b expected 0", tb_t, out_active);
      end
    end
    do_start();
    push(4, 10, 'h60, 'hC);
    while (tb_t < 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_active, out_first, out_last, running, late_err, in_ready} !== 6'b000001 ||
        {out_freq, out_env_addr, time_now, q_count} !== '0) begin
      n_bad++;
      $display("FAIL rst_midplay: got act %b run %b env %h fq %h t %0d cnt %0d expected all 0",
               out_active, running, out_env_addr, out_freq, time_now, q_count);
    end
    do_start();
    tick();
    tick();
    tick();
    n_cmp++;
    if (time_now !== 16'd3) begin
      n_bad++;
      $display("FAIL restart_time: got %0d expected 3", time_now);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_late();
    test_full();
    test_tlen0_wrap();
    test_start_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
